// File: rtl/mdu_if.sv
// Request, divider AXI-stream and HI/LO write-port signals of the multiply/divide unit.
// The slave modport is the controller's view; master is the surrounding EX stage / divider IPs.
interface mdu_if #(
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic [1:0]            req_op;
    logic [DATA_W-1:0]     req_src1;
    logic [DATA_W-1:0]     req_src2;
    logic                  flush;
    logic                  stall;
    logic [DATA_W-1:0]     div_dividend;
    logic [DATA_W-1:0]     div_divisor;
    logic                  div_s_tvalid;
    logic                  div_s_tready;
    logic                  div_s_dout_tvalid;
    logic [2*DATA_W-1:0]   div_s_dout;
    logic                  div_u_tvalid;
    logic                  div_u_tready;
    logic                  div_u_dout_tvalid;
    logic [2*DATA_W-1:0]   div_u_dout;
    logic                  hilo_we;
    logic [DATA_W-1:0]     hi_wdata;
    logic [DATA_W-1:0]     lo_wdata;
    logic                  done;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
        input  div_s_tready, div_s_dout_tvalid, div_s_dout,
        input  div_u_tready, div_u_dout_tvalid, div_u_dout,
        output stall, div_dividend, div_divisor, div_s_tvalid, div_u_tvalid,
        output hilo_we, hi_wdata, lo_wdata, done
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
        output div_s_tready, div_s_dout_tvalid, div_s_dout,
        output div_u_tready, div_u_dout_tvalid, div_u_dout,
        input  stall, div_dividend, div_divisor, div_s_tvalid, div_u_tvalid,
        input  hilo_we, hi_wdata, lo_wdata, done
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: one op in flight, drives the divider IP handshakes,
// stalls EX until HI/LO is committed, and drains cancelled divides so stale results never land.
module mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, MUL, WB} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic signed [DATA_W-1:0]  src1_q, src1_d;
    logic signed [DATA_W-1:0]  src2_q, src2_d;
    logic [DATA_W-1:0]         hi_q, hi_d;
    logic [DATA_W-1:0]         lo_q, lo_d;

    logic                      s_tvalid, u_tvalid, we, done_pulse;
    logic                      sel_tready, sel_dv;
    logic [2*DATA_W-1:0]       sel_dout;
    logic signed [2*DATA_W-1:0] mul_a, mul_b, prod;

    // Sign- or zero-extend to full width so one multiplier serves mult and multu.
    assign mul_a = op_q[0] ? {{DATA_W{1'b0}}, src1_q} : {{DATA_W{src1_q[DATA_W-1]}}, src1_q};
    assign mul_b = op_q[0] ? {{DATA_W{1'b0}}, src2_q} : {{DATA_W{src2_q[DATA_W-1]}}, src2_q};
    assign prod  = mul_a * mul_b;

    assign sel_tready = op_q[0] ? bus.div_u_tready      : bus.div_s_tready;
    assign sel_dv     = op_q[0] ? bus.div_u_dout_tvalid : bus.div_s_dout_tvalid;
    assign sel_dout   = op_q[0] ? bus.div_u_dout        : bus.div_s_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        s_tvalid   = 1'b0;
        u_tvalid   = 1'b0;
        we         = 1'b0;
        done_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    op_d    = bus.req_op;
                    src1_d  = bus.req_src1;
                    src2_d  = bus.req_src2;
                    state_d = bus.req_op[1] ? ISSUE : MUL;
                end
            end
            ISSUE: begin
                s_tvalid = !op_q[0];
                u_tvalid = op_q[0];
                // A transfer that completes alongside a flush still owes us a result to drain.
                if (sel_tready)    state_d = bus.flush ? DRAIN : WAIT;
                else if (bus.flush) state_d = IDLE;
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = sel_dv ? IDLE : DRAIN;
                end else if (sel_dv) begin
                    hi_d    = sel_dout[DATA_W-1:0];
                    lo_d    = sel_dout[2*DATA_W-1:DATA_W];
                    state_d = WB;
                end
            end
            DRAIN: begin
                if (sel_dv) state_d = IDLE;
            end
            MUL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = prod[2*DATA_W-1:DATA_W];
                    lo_d    = prod[DATA_W-1:0];
                    state_d = WB;
                end
            end
            WB: begin
                we         = !bus.flush;
                done_pulse = !bus.flush;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall        = bus.req_valid && (state_q != WB);
    assign bus.div_dividend = src1_q;
    assign bus.div_divisor  = src2_q;
    assign bus.div_s_tvalid = s_tvalid;
    assign bus.div_u_tvalid = u_tvalid;
    assign bus.hilo_we      = we;
    assign bus.done         = done_pulse;
    assign bus.hi_wdata     = hi_q;
    assign bus.lo_wdata     = lo_q;
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the multiply/divide unit used by the EX stage. It accepts one mult/multu/div/divu request at a time and drives the AXI-stream handshake of the signed and unsigned divider IPs. It stalls the pipeline until the result is ready and commits the result to HI/LO through a single write port. A pipeline flush cancels the commit; an in-flight divide is drained so that its late result is never written.

Parameters:
DATA_W, 32, operand width; HI/LO width; divider dout is 2*DATA_W

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  EX stage holds an MDU instruction
req_op  in  2  00 mult, 01 multu, 10 div, 11 divu
req_src1  in  DATA_W  multiplicand / dividend
req_src2  in  DATA_W  multiplier / divisor
flush  in  1  exception in EX or MEM1; kill current op
stall  out  1  hold EX stage
div_dividend  out  DATA_W  registered src1 to both dividers
div_divisor  out  DATA_W  registered src2 to both dividers
div_s_tvalid  out  1  dividend+divisor tvalid, signed IP
div_s_tready  in  1  AND of both tready, signed IP
div_s_dout_tvalid  in  1  signed result valid
div_s_dout  in  2*DATA_W  [63:32] quotient, [31:0] remainder
div_u_tvalid, div_u_tready, div_u_dout_tvalid, div_u_dout: same roles for the unsigned IP
hilo_we  out  1  one-cycle write strobe
hi_wdata  out  DATA_W  value for HI
lo_wdata  out  DATA_W  value for LO
done  out  1  one-cycle pulse on commit

Behaviour:
- Reset values: state IDLE; stall 0; div_s_tvalid and div_u_tvalid 0; hilo_we 0; done 0; operand and result registers 0.
- States: IDLE, ISSUE, WAIT, DRAIN, MUL, WB. The FSM is registered. Outputs are decoded from state and inputs, as listed below.
- IDLE:
  - req_valid & ~flush: latch src1, src2 and op. op[1]=1 goes to ISSUE; op[1]=0 goes to MUL.
  - A dout_tvalid arriving in IDLE is ignored (stale result after reset).
- ISSUE:
  - The tvalid of the selected IP (op[0]=0 signed, op[0]=1 unsigned) is 1. The other IP's tvalid is 0.
  - tvalid & tready: go to WAIT. tvalid is 0 from the next cycle on, so exactly one transfer occurs.
  - flush with handshake in the same cycle: go to DRAIN.
  - flush without handshake: go to IDLE. tvalid drops and no transfer occurs.
- WAIT:
  - Selected dout_tvalid: capture hi=dout[31:0] (remainder) and lo=dout[63:32] (quotient), then go to WB.
  - flush: go to DRAIN.
  - If dout_tvalid and flush occur together, flush wins and the FSM goes to IDLE.
- DRAIN: wait for the selected dout_tvalid, discard the result, then go to IDLE. flush has no effect in DRAIN.
- MUL:
  - Register the 64-bit product. Use signed*signed when op[0]=0 and unsigned when op[0]=1. hi=[63:32], lo=[31:0].
  - Then go to WB. flush goes to IDLE.
- WB:
  - hilo_we=1 and done=1 for exactly one cycle, then go to IDLE.
  - flush in WB forces hilo_we=0 and done=0. The FSM still goes to IDLE.
- stall = req_valid & (state != WB). It is therefore 1 in IDLE on the request cycle, and 1 in DRAIN while a new request waits.
- Latency, accept to hilo_we:
  - mult/multu: 2 cycles.
  - div/divu: 1 + tready wait + IP latency + 1 cycles.
- Divide by zero: the IP result is committed unchanged. No exception is raised.
- Reset mid-operation goes to IDLE immediately and clears tvalid. Results still pending from the IP are discarded by the IDLE rule.
- Only one operation is in flight. Back-to-back requests are accepted in the cycle after WB, or after DRAIN.

Test Plan:
- div, src1=0xFFFFFFF9 (-7), src2=2 -> one tvalid handshake on the signed IP. On the dout cycle+1: hilo_we=1, hi=0xFFFFFFFF, lo=0xFFFFFFFD. stall=1 until WB.
- divu, src1=100, src2=7 -> only div_u_tvalid asserts. hi=2, lo=14. div_s_tvalid stays 0 throughout.
- mult 0xFFFFFFFF*2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, 2 cycles after accept. multu, same operands -> hi=1, lo=0xFFFFFFFE.
- div accepted, then flush in WAIT, next div presented immediately -> DRAIN swallows the first dout with no hilo_we. stall=1 until the first dout. The second div is then issued and commits normally.
- Hold tready=0 for 5 cycles in ISSUE -> tvalid stays 1 with operands stable. Flush at cycle 3 -> tvalid 0 next cycle, IDLE, zero transfers counted.
- reset asserted in WAIT, then IP dout_tvalid arrives 3 cycles later -> no hilo_we, no done, state IDLE, all outputs at reset values.
